// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports, one transaction at a time.
// Optional ARB_FAIR_EN bounds consecutive data grants while a fetch waits (MAX_DATA_RUN).
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int READ_LATENCY = 1,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InstrReq,
  input  logic [WORD_SIZE-1:0] InstrAddr,
  output logic [WORD_SIZE-1:0] InstrIn,
  output logic                 InstrWaitreq,
  input  logic                 DataRead,
  input  logic                 DataWrite,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  output logic [WORD_SIZE-1:0] MemAddr,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [WORD_SIZE-1:0] MemWriteData,
  input  logic [WORD_SIZE-1:0] MemReadData,
  input  logic                 MemWaitreq
);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state, state_nxt;
  logic                 grant_instr, is_write;
  logic [LAT_W-1:0]     lat_cnt;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 data_req, any_req, pick_instr;

  // Unsupported parameter values show up as this block in the elaborated hierarchy.
  if (READ_LATENCY < 1 || MAX_DATA_RUN < 1) begin : g_illegal_params
  end

  assign data_req = DataRead | DataWrite;
  assign any_req  = data_req | InstrReq;

`ifdef ARB_FAIR_EN
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  logic [RUN_W-1:0] run_cnt;
  logic             fetch_due;

  assign fetch_due  = InstrReq && (run_cnt >= RUN_W'(MAX_DATA_RUN));
  assign pick_instr = InstrReq && (!data_req || fetch_due);

  // Counts data wins only while a fetch is being held off.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                        run_cnt <= '0;
    else if (state == IDLE && any_req) begin
      if (pick_instr || !InstrReq)    run_cnt <= '0;
      else                            run_cnt <= run_cnt + 1'b1;
    end
  end
`else
  assign pick_instr = InstrReq && !data_req;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   if (!MemWaitreq) state_nxt = is_write ? RESP : WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      MemAddr      <= '0;
      MemWriteData <= '0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      rdata_q      <= '0;
      lat_cnt      <= '0;
      grant_instr  <= 1'b0;
      is_write     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant_instr <= pick_instr;
          if (pick_instr) begin
            MemAddr  <= InstrAddr;
            MemRead  <= 1'b1;
            MemWrite <= 1'b0;
            is_write <= 1'b0;
          end else begin
            // Read+write together is resolved as a write.
            MemAddr      <= DataAddr;
            MemWriteData <= DataOut;
            MemRead      <= !DataWrite;
            MemWrite     <= DataWrite;
            is_write     <= DataWrite;
          end
        end
        ISSUE: if (!MemWaitreq) begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          lat_cnt  <= LAT_W'(READ_LATENCY - 1);
        end
        WAIT: begin
          if (lat_cnt == '0) rdata_q <= MemReadData;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign InstrWaitreq = InstrReq && !(state == RESP && grant_instr);
  assign DataWaitreq  = data_req && !(state == RESP && !grant_instr);
  assign InstrIn      = rdata_q;
  assign DataIn       = rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level timing model.
module tb_mem_port_arbiter;
  localparam int W      = 16;
  localparam int RL     = 3;
  localparam int MAXRUN = 4;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         InstrReq, InstrWaitreq;
  logic [W-1:0] InstrAddr, InstrIn;
  logic         DataRead, DataWrite, DataWaitreq;
  logic [W-1:0] DataAddr, DataOut, DataIn;
  logic [W-1:0] MemAddr, MemWriteData, MemReadData;
  logic         MemRead, MemWrite, MemWaitreq;

  mem_port_arbiter #(.WORD_SIZE(W), .READ_LATENCY(RL), .MAX_DATA_RUN(MAXRUN)) u_dut (
    .Clock(Clock), .Reset(Reset),
    .InstrReq(InstrReq), .InstrAddr(InstrAddr), .InstrIn(InstrIn), .InstrWaitreq(InstrWaitreq),
    .DataRead(DataRead), .DataWrite(DataWrite), .DataAddr(DataAddr), .DataOut(DataOut),
    .DataIn(DataIn), .DataWaitreq(DataWaitreq),
    .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite), .MemWriteData(MemWriteData),
    .MemReadData(MemReadData), .MemWaitreq(MemWaitreq)
  );

  always #5 Clock = ~Clock;

  function automatic logic [W-1:0] seed_val(input int i);
    return W'(32'hA5C3 ^ (i * 32'h1357));
  endfunction

  // Memory environment: read data follows the last accepted read address.
  logic [W-1:0] env_mem [16];
  logic [3:0]   rd_addr_q = 4'd0;
  logic         mem_seeded = 1'b0;
  assign MemReadData = env_mem[rd_addr_q];

  always @(posedge Clock) begin
    if (!mem_seeded) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= seed_val(i);
      mem_seeded <= 1'b1;
    end else begin
      if (MemWrite && !MemWaitreq) env_mem[MemAddr[3:0]] <= MemWriteData;
      if (MemRead && !MemWaitreq)  rd_addr_q <= MemAddr[3:0];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
    end
  endtask

  // Reference model state (one outstanding transaction, time-stamped completion)
  logic [W-1:0] ref_mem [16];
  logic         busy, acc, m_instr, m_wr;
  logic [W-1:0] m_addr, m_wdata, m_rdata;
  int           resp_cyc, run;
  logic         d_act, i_act;

  task automatic model_step();
    logic resp, stb, dreq, pick_i;
    dreq = DataRead | DataWrite;
    if (Reset) begin
      chk("rst_mrd", MemRead, 1'b0);
      chk("rst_mwr", MemWrite, 1'b0);
      chk("rst_maddr", MemAddr, '0);
      chk("rst_rdata", DataIn, '0);
      chk("rst_iwait", InstrWaitreq, InstrReq);
      chk("rst_dwait", DataWaitreq, dreq);
      busy = 1'b0;
      run  = 0;
      return;
    end
    resp = busy && acc && (cyc == resp_cyc);
    stb  = busy && !acc;
    chk("iwait", InstrWaitreq, InstrReq && !(resp && m_instr));
    chk("dwait", DataWaitreq, dreq && !(resp && !m_instr));
    chk("mrd", MemRead, stb && !m_wr);
    chk("mwr", MemWrite, stb && m_wr);
    if (stb) chk("maddr", MemAddr, m_addr);
    if (stb && m_wr) chk("mwdata", MemWriteData, m_wdata);
    if (resp && !m_wr) begin
      if (m_instr) chk("instr_in", InstrIn, m_rdata);
      else         chk("data_in", DataIn, m_rdata);
    end
    if (resp) busy = 1'b0;
    else if (stb && !MemWaitreq) begin
      acc      = 1'b1;
      resp_cyc = cyc + (m_wr ? 1 : RL + 1);
      if (m_wr) ref_mem[m_addr[3:0]] = m_wdata;
      else      m_rdata = ref_mem[m_addr[3:0]];
    end else if (!busy && (dreq || InstrReq)) begin
`ifdef ARB_FAIR_EN
      pick_i = InstrReq && (!dreq || run >= MAXRUN);
      run    = (pick_i || !InstrReq) ? 0 : run + 1;
`else
      pick_i = InstrReq && !dreq;
`endif
      busy    = 1'b1;
      acc     = 1'b0;
      m_instr = pick_i;
      m_wr    = !pick_i && DataWrite;
      m_addr  = pick_i ? InstrAddr : DataAddr;
      m_wdata = DataOut;
    end
  endtask

  initial begin
    logic sat;
    int   k;
    Reset = 1'b1;
    InstrReq = 1'b0; InstrAddr = '0;
    DataRead = 1'b0; DataWrite = 1'b0; DataAddr = '0; DataOut = '0;
    MemWaitreq = 1'b0;
    busy = 1'b0; acc = 1'b0; m_instr = 1'b0; m_wr = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; resp_cyc = 0; run = 0;
    d_act = 1'b0; i_act = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = seed_val(i);

    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("reset_mrd", MemRead, 1'b0);
    chk("reset_mwr", MemWrite, 1'b0);
    chk("reset_maddr", MemAddr, '0);
    chk("reset_mwdata", MemWriteData, '0);
    chk("reset_instr_in", InstrIn, '0);
    chk("reset_iwait", InstrWaitreq, 1'b0);
    chk("reset_dwait", DataWaitreq, 1'b0);

    for (int c = 0; c < 4000; c++) begin
      @(posedge Clock);
      #1;
      sat   = (c >= 2000 && c < 3000);
      Reset = (c > 200) && ($urandom_range(0, 59) == 0);
      MemWaitreq = sat ? 1'b0 : ($urandom_range(0, 3) == 0);
      if (!d_act && (sat || $urandom_range(0, 1) == 1)) begin
        d_act     = 1'b1;
        k         = $urandom_range(0, 7);
        DataWrite = (k >= 4);
        DataRead  = (k < 4) || (k == 7);
        DataAddr  = W'($urandom_range(0, 15));
        DataOut   = W'($urandom);
      end else if (!d_act) begin
        DataRead  = 1'b0;
        DataWrite = 1'b0;
      end
      if (!i_act && (sat || $urandom_range(0, 1) == 1)) begin
        i_act     = 1'b1;
        InstrReq  = 1'b1;
        InstrAddr = W'($urandom_range(0, 15));
      end else if (!i_act) begin
        InstrReq = 1'b0;
      end
      @(negedge Clock);
      cyc++;
      model_step();
      if (!Reset && d_act && !DataWaitreq)  d_act = 1'b0;
      if (!Reset && i_act && !InstrWaitreq) i_act = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
